// File: rtl/traffic_signal_conflict_monitor.sv
// Purpose : receive-side legality checker for the T-junction lamp outputs. Decodes the
//           T1/T2 one-hot lamp codes into phases, times each phase and checks code validity,
//           conflicts, sequence, minimum dwell, stuck red and walk-on-green. The first fault
//           is latched and drives flash_req for the lamp driver's fail-safe flash path.
// Ports   : clk, reset (async, active-high)
//           T1, T2 {R,Y,G} lamp codes; T1_walk, T2_walk walk lamps
//           emg_active (legalises early cut to RED), fault_clr (clear latched fault)
//           phase_T1/phase_T2 (combinational decode: 00 R, 01 G, 10 Y, 11 invalid)
//           cycle_done (pulse per legal T1 R->G->Y->R), fault, fault_code, fault_src, flash_req
module traffic_signal_conflict_monitor #(
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned MIN_GREEN  = 10,
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MAX_RED    = 700
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] T1,
  input  logic [2:0] T2,
  input  logic       T1_walk,
  input  logic       T2_walk,
  input  logic       emg_active,
  input  logic       fault_clr,
  output logic [1:0] phase_T1,
  output logic [1:0] phase_T2,
  output logic       cycle_done,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_src,
  output logic       flash_req
);

  localparam logic [1:0] PH_RED = 2'b00;
  localparam logic [1:0] PH_GRN = 2'b01;
  localparam logic [1:0] PH_YEL = 2'b10;
  localparam logic [1:0] PH_BAD = 2'b11;

  typedef enum logic [1:0] {C_IDLE, C_RG, C_GY} cyc_state_t;

  // One-hot lamp code to phase; anything else is invalid.
  function automatic logic [1:0] decode_ph(input logic [2:0] code);
    case (code)
      3'b100:  decode_ph = PH_RED;
      3'b001:  decode_ph = PH_GRN;
      3'b010:  decode_ph = PH_YEL;
      default: decode_ph = PH_BAD;
    endcase
  endfunction

  // Index 0 = T1, index 1 = T2.
  logic [1:0][2:0]       w_code_in;
  logic [1:0]            w_walk_in;
  logic [1:0][1:0]       w_ph;
  logic [1:0]            w_valid, w_chg;
  logic [1:0]            w_bad_code, w_bad_seq, w_short_g, w_short_y, w_stuck, w_walk_g;
  logic                  w_conflict, w_viol, w_cycle_done;
  logic [2:0]            w_code;
  logic [1:0]            w_src;
  cyc_state_t            w_cstate_nxt;

  logic [1:0][1:0]       r_prev;
  logic [1:0][CNT_W-1:0] r_cnt;
  logic [1:0]            r_armed;
  cyc_state_t            r_cstate;
  logic                  r_cycle_done, r_fault;
  logic [2:0]            r_code;
  logic [1:0]            r_src;

  assign w_code_in = {T2, T1};
  assign w_walk_in = {T2_walk, T1_walk};

  // Per-approach checks of current inputs against registered phase history.
  always_comb begin
    w_ph       = '0;
    w_valid    = '0;
    w_chg      = '0;
    w_bad_code = '0;
    w_bad_seq  = '0;
    w_short_g  = '0;
    w_short_y  = '0;
    w_stuck    = '0;
    w_walk_g   = '0;
    for (int i = 0; i < 2; i++) begin
      w_ph[i]       = decode_ph(w_code_in[i]);
      w_valid[i]    = (w_ph[i] != PH_BAD);
      w_chg[i]      = w_valid[i] && (w_ph[i] != r_prev[i]);
      w_bad_code[i] = !w_valid[i];
      // Ending-phase dwell is counter+1; sequence and dwell checks wait for arming.
      w_bad_seq[i]  = r_armed[i] && w_chg[i] &&
                      (((r_prev[i] == PH_RED) && (w_ph[i] == PH_YEL)) ||
                       ((r_prev[i] == PH_YEL) && (w_ph[i] == PH_GRN)) ||
                       ((r_prev[i] == PH_GRN) && (w_ph[i] == PH_RED) && !emg_active));
      w_short_g[i]  = r_armed[i] && w_chg[i] && (r_prev[i] == PH_GRN) && (w_ph[i] == PH_YEL) &&
                      ((32'(r_cnt[i]) + 32'd1) < MIN_GREEN);
      w_short_y[i]  = r_armed[i] && w_chg[i] && (r_prev[i] == PH_YEL) && (w_ph[i] == PH_RED) &&
                      ((32'(r_cnt[i]) + 32'd1) < MIN_YELLOW) && !emg_active;
      w_stuck[i]    = (w_ph[i] == PH_RED) && (r_prev[i] == PH_RED) && (32'(r_cnt[i]) >= MAX_RED);
      w_walk_g[i]   = w_walk_in[i] && (w_ph[i] == PH_GRN);
    end
  end

  assign w_conflict = (w_ph[0] != PH_RED) && (w_ph[1] != PH_RED);

  // Lowest fault code wins; source is every approach flagging that code.
  always_comb begin
    w_code = 3'd0;
    w_src  = 2'b00;
    if (|w_bad_code) begin
      w_code = 3'd1; w_src = w_bad_code;
    end else if (w_conflict) begin
      w_code = 3'd2; w_src = 2'b11;
    end else if (|w_bad_seq) begin
      w_code = 3'd3; w_src = w_bad_seq;
    end else if (|w_short_g) begin
      w_code = 3'd4; w_src = w_short_g;
    end else if (|w_short_y) begin
      w_code = 3'd5; w_src = w_short_y;
    end else if (|w_stuck) begin
      w_code = 3'd6; w_src = w_stuck;
    end else if (|w_walk_g) begin
      w_code = 3'd7; w_src = w_walk_g;
    end
  end

  assign w_viol = (w_code != 3'd0);

  // Phase history, saturating dwell counters and arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev  <= '0;
      r_cnt   <= '0;
      r_armed <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!w_valid[i]) begin
          r_armed[i] <= 1'b0;
        end else if (w_chg[i]) begin
          r_cnt[i]   <= '0;
          r_prev[i]  <= w_ph[i];
          r_armed[i] <= 1'b1;
        end else if (r_cnt[i] != {CNT_W{1'b1}}) begin
          r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // T1 cycle tracker state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cstate     <= C_IDLE;
      r_cycle_done <= 1'b0;
    end else begin
      r_cstate     <= w_cstate_nxt;
      r_cycle_done <= w_cycle_done;
    end
  end

  // T1 cycle tracker: remembers a legal R->G then G->Y; completes on a legal armed Y->R.
  always_comb begin
    w_cstate_nxt = r_cstate;
    w_cycle_done = 1'b0;
    if (!w_valid[0]) begin
      w_cstate_nxt = C_IDLE;
    end else if (w_chg[0]) begin
      w_cstate_nxt = C_IDLE;
      if ((r_prev[0] == PH_RED) && (w_ph[0] == PH_GRN)) begin
        w_cstate_nxt = C_RG;
      end else if ((r_prev[0] == PH_GRN) && (w_ph[0] == PH_YEL)) begin
        if ((r_cstate == C_RG) && !w_short_g[0]) w_cstate_nxt = C_GY;
      end else if ((r_prev[0] == PH_YEL) && (w_ph[0] == PH_RED)) begin
        w_cycle_done = (r_cstate == C_GY) && r_armed[0] && !w_short_y[0];
      end
    end
  end

  // First-fault latch; clear only honoured on a violation-free cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
      r_code  <= 3'd0;
      r_src   <= 2'b00;
    end else if (!r_fault) begin
      if (w_viol) begin
        r_fault <= 1'b1;
        r_code  <= w_code;
        r_src   <= w_src;
      end
    end else if (fault_clr && !w_viol) begin
      r_fault <= 1'b0;
      r_code  <= 3'd0;
      r_src   <= 2'b00;
    end
  end

  // Phase decode is forced to RED while reset is asserted.
  assign phase_T1   = reset ? PH_RED : w_ph[0];
  assign phase_T2   = reset ? PH_RED : w_ph[1];
  assign cycle_done = r_cycle_done;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign fault_src  = r_src;
  assign flash_req  = r_fault;

endmodule

// File: tb/tb_traffic_signal_conflict_monitor.sv
module tb_traffic_signal_conflict_monitor;

  localparam int MIN_GREEN  = 10;
  localparam int MIN_YELLOW = 3;
  localparam int MAX_RED    = 700;
  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] T1, T2;
  logic       T1_walk, T2_walk, emg_active, fault_clr;
  logic [1:0] phase_T1, phase_T2;
  logic       cycle_done, fault, flash_req;
  logic [2:0] fault_code;
  logic [1:0] fault_src;

  traffic_signal_conflict_monitor dut (
    .clk(clk), .reset(reset), .T1(T1), .T2(T2), .T1_walk(T1_walk), .T2_walk(T2_walk),
    .emg_active(emg_active), .fault_clr(fault_clr), .phase_T1(phase_T1), .phase_T2(phase_T2),
    .cycle_done(cycle_done), .fault(fault), .fault_code(fault_code), .fault_src(fault_src),
    .flash_req(flash_req)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: phases as ints (0 red, 1 green, 2 yellow, 3 invalid), cycles since change.
  typedef struct { int from; int to; bit ok; } trans_t;
  int         m_ph [2];
  int         m_cnt[2];
  bit         m_armed[2];
  bit         m_fault;
  logic [2:0] m_code;
  logic [1:0] m_src;
  bit         m_cd;
  logic [1:0] m_dph[2];
  trans_t     m_hist[$];

  function automatic int bench_ph(input logic [2:0] c);
    if ($countones(c) != 1) return 3;
    if (c[2]) return 0;
    if (c[0]) return 1;
    return 2;
  endfunction

  function automatic logic [11:0] obs();
    return {phase_T1, phase_T2, cycle_done, fault, fault_code, fault_src, flash_req};
  endfunction

  function automatic logic [11:0] expv();
    return {m_dph[0], m_dph[1], m_cd, m_fault, m_code, m_src, m_fault};
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] c);
    if (c == LR) return LG;
    if (c == LG) return LY;
    return LR;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_cnt[i] = 0; m_armed[i] = 0; m_dph[i] = 2'b00;
    end
    m_fault = 0; m_code = 3'd0; m_src = 2'b00; m_cd = 0;
    m_hist.delete();
  endtask

  // Evaluate the rules on the inputs about to be sampled, then advance the model.
  task automatic model_step();
    logic [2:0] c[2];
    bit         wk[2];
    logic [1:0] fl[8];
    int         ph[2];
    bit         chg[2];
    int         code;
    logic [1:0] src;
    trans_t     t;
    c[0] = T1; c[1] = T2; wk[0] = T1_walk; wk[1] = T2_walk;
    for (int k = 0; k < 8; k++) fl[k] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ph[i]    = bench_ph(c[i]);
      m_dph[i] = 2'(ph[i]);
      chg[i]   = (ph[i] != 3) && (ph[i] != m_ph[i]);
      if (ph[i] == 3) fl[1][i] = 1'b1;
      if (chg[i] && m_armed[i]) begin
        if (!((m_ph[i] == 0 && ph[i] == 1) || (m_ph[i] == 1 && ph[i] == 2) ||
              (m_ph[i] == 2 && ph[i] == 0) || (m_ph[i] == 1 && ph[i] == 0 && emg_active)))
          fl[3][i] = 1'b1;
        if (m_ph[i] == 1 && ph[i] == 2 && m_cnt[i] + 1 < MIN_GREEN) fl[4][i] = 1'b1;
        if (m_ph[i] == 2 && ph[i] == 0 && m_cnt[i] + 1 < MIN_YELLOW && !emg_active) fl[5][i] = 1'b1;
      end
      if (ph[i] == 0 && m_ph[i] == 0 && m_cnt[i] >= MAX_RED) fl[6][i] = 1'b1;
      if (wk[i] && ph[i] == 1) fl[7][i] = 1'b1;
    end
    if (ph[0] != 0 && ph[1] != 0) fl[2] = 2'b11;
    code = 0; src = 2'b00;
    for (int k = 7; k >= 1; k--) if (fl[k] != 2'b00) begin code = k; src = fl[k]; end

    m_cd = 0;
    if (chg[0] && m_ph[0] == 2 && ph[0] == 0 && m_armed[0] && !fl[5][0] && m_hist.size() >= 2) begin
      if (m_hist[m_hist.size()-2].from == 0 && m_hist[m_hist.size()-2].to == 1 &&
          m_hist[m_hist.size()-2].ok && m_hist[m_hist.size()-1].from == 1 &&
          m_hist[m_hist.size()-1].to == 2 && m_hist[m_hist.size()-1].ok)
        m_cd = 1;
    end
    if (ph[0] == 3) m_hist.delete();
    else if (chg[0]) begin
      t.from = m_ph[0]; t.to = ph[0]; t.ok = !(fl[3][0] || fl[4][0] || fl[5][0]);
      m_hist.push_back(t);
      if (m_hist.size() > 2) void'(m_hist.pop_front());
    end

    if (!m_fault && code != 0) begin
      m_fault = 1; m_code = 3'(code); m_src = src;
    end else if (m_fault && fault_clr && code == 0) begin
      m_fault = 0; m_code = 3'd0; m_src = 2'b00;
    end

    for (int i = 0; i < 2; i++) begin
      if (ph[i] == 3) m_armed[i] = 0;
      else if (chg[i]) begin m_cnt[i] = 0; m_ph[i] = ph[i]; m_armed[i] = 1; end
      else if (m_cnt[i] < 1023) m_cnt[i]++;
    end
  endtask

  task automatic apply(input logic [2:0] a, input logic [2:0] b, input logic wa, input logic wb,
                       input logic e, input logic clr);
    T1 = a; T2 = b; T1_walk = wa; T2_walk = wb; emg_active = e; fault_clr = clr;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    T1 = LR; T2 = LR; T1_walk = 0; T2_walk = 0; emg_active = 0; fault_clr = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (obs() !== 12'h000) begin
      nerr++; $display("FAIL reset_state got=%h exp=000", obs());
    end
    apply(3'b011, LR, 0, 0, 0, 0);
    nvec++;
    if (obs() !== expv()) begin nerr++; $display("FAIL reset_prefault got=%h exp=%h", obs(), expv()); end
    T1 = LG;
    #2;
    reset = 1'b1;
    #1;
    nvec++;
    if ({fault, fault_code, phase_T1, flash_req} !== 7'b0) begin
      nerr++; $display("FAIL reset_async got=%b exp=0000000", {fault, fault_code, phase_T1, flash_req});
    end
    T1 = LR;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      apply(LR, LR, 1'(k % 2), 0, 0, 0);
      nvec++;
      if (obs() !== expv()) begin nerr++; $display("FAIL reset_after k=%0d got=%h exp=%h", k, obs(), expv()); end
    end
  endtask

  task automatic test_normal_cycle();
    int pulses = 0;
    logic [2:0] a, b;
    do_reset();
    for (int it = 0; it < 3; it++) begin
      for (int j = 0; j < 77; j++) begin
        a = (j < 40) ? LR : (j < 71) ? LG : LY;
        b = (j >= 40 || j < 2 || j >= 36) ? LR : (j < 32) ? LG : LY;
        apply(a, b, (a == LR) ? 1'($urandom_range(0, 1)) : 1'b0,
              (b == LR) ? 1'($urandom_range(0, 1)) : 1'b0, 0, 0);
        if (cycle_done === 1'b1) pulses++;
        nvec++;
        if (obs() !== expv()) begin nerr++; $display("FAIL normal it=%0d j=%0d got=%h exp=%h", it, j, obs(), expv()); end
      end
    end
    apply(LR, LR, 0, 0, 0, 0);
    if (cycle_done === 1'b1) pulses++;
    nvec++;
    if (obs() !== expv()) begin nerr++; $display("FAIL normal_tail got=%h exp=%h", obs(), expv()); end
    nvec++;
    if (pulses != 3 || fault !== 1'b0) begin
      nerr++; $display("FAIL normal_pulses got=%0d fault=%b exp=3 fault=0", pulses, fault);
    end
  endtask

  task automatic test_bad_code();
    do_reset();
    apply(3'b011, LR, 0, 0, 0, 0);
    nvec++;
    if ({fault, fault_code, fault_src, flash_req} !== {1'b1, 3'd1, 2'b01, 1'b1}) begin
      nerr++; $display("FAIL bad_code got=%b exp=1001011", {fault, fault_code, fault_src, flash_req});
    end
    nvec++;
    if (obs() !== expv()) begin nerr++; $display("FAIL bad_code_model got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_short_green();
    logic [2:0] codes[6];
    int         lens[6];
    codes = '{LR, LG, LY, LR, LG, LY};
    for (int g = 9; g <= 10; g++) begin
      lens = '{3, 12, 4, 3, g, 1};
      do_reset();
      for (int s = 0; s < 6; s++) begin
        for (int k = 0; k < lens[s]; k++) begin
          apply(codes[s], LR, 0, 0, 0, 0);
          nvec++;
          if (obs() !== expv()) begin nerr++; $display("FAIL short_green g=%0d s=%0d got=%h exp=%h", g, s, obs(), expv()); end
        end
      end
      nvec++;
      if (g == 9 && {fault, fault_code, fault_src} !== {1'b1, 3'd4, 2'b01}) begin
        nerr++; $display("FAIL short_green9 got=%b exp=110001", {fault, fault_code, fault_src});
      end else if (g == 10 && fault !== 1'b0) begin
        nerr++; $display("FAIL short_green10 got=%b exp=0", fault);
      end
    end
  endtask

  task automatic test_emg();
    logic [2:0] codes[9];
    int         lens[9];
    codes = '{LR, LG, LY, LR, LG, LR, LR, LG, LR};
    lens  = '{2, 12, 4, 3, 12, 1, 3, 12, 1};
    do_reset();
    for (int s = 0; s < 9; s++) begin
      for (int k = 0; k < lens[s]; k++) begin
        apply(LR, codes[s], 0, 0, (s == 5) ? 1'b1 : 1'b0, 0);
        nvec++;
        if (obs() !== expv()) begin nerr++; $display("FAIL emg s=%0d got=%h exp=%h", s, obs(), expv()); end
      end
      if (s == 5) begin
        nvec++;
        if (fault !== 1'b0) begin nerr++; $display("FAIL emg_cut got=%b exp=0", fault); end
      end
    end
    nvec++;
    if ({fault, fault_code, fault_src} !== {1'b1, 3'd3, 2'b10}) begin
      nerr++; $display("FAIL emg_badseq got=%b exp=101110", {fault, fault_code, fault_src});
    end
  endtask

  task automatic test_conflict_clr();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply(LG, LG, 0, 0, 0, 1);
      nvec++;
      if (obs() !== expv()) begin nerr++; $display("FAIL conflict k=%0d got=%h exp=%h", k, obs(), expv()); end
    end
    nvec++;
    if ({fault, fault_code, fault_src} !== {1'b1, 3'd2, 2'b11}) begin
      nerr++; $display("FAIL conflict_hold got=%b exp=101011", {fault, fault_code, fault_src});
    end
    apply(LG, LR, 0, 0, 0, 0);
    apply(LG, LR, 0, 0, 0, 1);
    nvec++;
    if ({fault, fault_code, fault_src} !== 6'b0) begin
      nerr++; $display("FAIL conflict_clear got=%b exp=000000", {fault, fault_code, fault_src});
    end
    nvec++;
    if (obs() !== expv()) begin nerr++; $display("FAIL conflict_clear_model got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_red_stuck();
    logic [2:0] b;
    int         p;
    do_reset();
    for (int k = 1; k <= 701; k++) begin
      p = (k - 1) % 40;
      b = (p >= 5 && p < 25) ? LG : (p >= 25 && p < 29) ? LY : LR;
      apply(LR, b, 0, 0, 0, 0);
      nvec++;
      if (obs() !== expv()) begin nerr++; $display("FAIL red_stuck k=%0d got=%h exp=%h", k, obs(), expv()); end
      if (k == 700) begin
        nvec++;
        if (fault !== 1'b0) begin nerr++; $display("FAIL red_stuck700 got=%b exp=0", fault); end
      end
    end
    nvec++;
    if ({fault, fault_code, fault_src} !== {1'b1, 3'd6, 2'b01}) begin
      nerr++; $display("FAIL red_stuck701 got=%b exp=111001", {fault, fault_code, fault_src});
    end
  endtask

  task automatic test_random();
    logic [2:0] c1, c2;
    int         dur;
    do_reset();
    c1 = LR; c2 = LR;
    for (int seg = 0; seg < 200; seg++) begin
      dur = $urandom_range(1, 14);
      case ($urandom_range(0, 15))
        0:                      c1 = 3'($urandom_range(0, 7));
        1, 2, 3, 4, 5, 6, 7, 8,
        9, 10, 11:              c1 = succ(c1);
        default:                c1 = c1;
      endcase
      if ($urandom_range(0, 19) == 0)   c2 = 3'($urandom_range(0, 7));
      else if (c1 == LR)                c2 = ($urandom_range(0, 1) != 0) ? succ(c2) : c2;
      else if ($urandom_range(0, 7) != 0) c2 = LR;
      for (int k = 0; k < dur; k++) begin
        apply(c1, c2, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
        nvec++;
        if (obs() !== expv()) begin nerr++; $display("FAIL random seg=%0d k=%0d got=%h exp=%h", seg, k, obs(), expv()); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    T1 = LR; T2 = LR; T1_walk = 0; T2_walk = 0; emg_active = 0; fault_clr = 0;
    model_reset();
    #12;
    test_reset();
    test_normal_cycle();
    test_bad_code();
    test_short_green();
    test_emg();
    test_conflict_clr();
    test_red_stuck();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
